// File: rtl/hps_adapter_util_scfifo.sv
// Single-clock show-ahead FIFO built on an MLAB-style storage array.
// Two register stages (memory dout, output register) follow the array, so
// the FIFO holds DEPTH+2 words. On S10 the write data is registered once
// more before it lands in the array, so reads of a fresh word wait one edge.

// Storage: synchronous write, registered read that holds when re=0.
module hps_adapter_util_generic_mlab_sc #(
    parameter int    WIDTH      = 8,
    parameter int    ADDR_WIDTH = 5,
    parameter string FAMILY     = "Other"
) (
    input  logic                  clk,
    input  logic [WIDTH-1:0]      din,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      dout
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [WIDTH-1:0]      dout_q;
    logic [WIDTH-1:0]      wr_data;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_en;

    generate
        if (FAMILY == "S10") begin : g_wreg
            logic [WIDTH-1:0]      din_q;
            logic [ADDR_WIDTH-1:0] waddr_q;
            logic                  we_q;
            // S10 input register: write lands in the array one edge late
            always_ff @(posedge clk) begin
                din_q   <= din;
                waddr_q <= waddr;
                we_q    <= we;
            end
            assign wr_data = din_q;
            assign wr_addr = waddr_q;
            assign wr_en   = we_q;
        end else begin : g_wdir
            assign wr_data = din;
            assign wr_addr = waddr;
            assign wr_en   = we;
        end
    endgenerate

    // Array write port
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    // Registered read; dout holds its value while no read is issued
    always_ff @(posedge clk) begin
        if (re) dout_q <= mem_q[raddr];
    end

    assign dout = dout_q;
endmodule

module hps_adapter_util_scfifo #(
    parameter int    WIDTH      = 8,
    parameter int    ADDR_WIDTH = 5,
    parameter string FAMILY     = "Other"
) (
    input  logic                  clk,
    input  logic                  aclr_n,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH+1:0] used
);
    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int CW     = ADDR_WIDTH + 1;
    localparam int UW     = ADDR_WIDTH + 2;
    localparam bit IS_S10 = (FAMILY == "S10");
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]         mem_cnt_q, mem_cnt_d, avail_q, avail_d;
    logic                  s1_v_q, s1_v_d, out_valid_q, out_valid_d;
    logic                  in_ready_q, in_ready_d, wr_pend_q, wr_pend_d;
    logic [WIDTH-1:0]      out_data_q, out_data_d, mem_dout;
    logic [UW-1:0]         used_q, used_d;
    logic                  wr, rd_issue, s1_adv, avail_inc;

    hps_adapter_util_generic_mlab_sc #(
        .WIDTH     (WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .FAMILY    (FAMILY)
    ) u_mem (
        .clk  (clk),
        .din  (in_data),
        .waddr(wptr_q),
        .we   (wr),
        .re   (rd_issue),
        .raddr(rptr_q),
        .dout (mem_dout)
    );

    // Handshakes, read scheduling and next-state for all counters/stages
    always_comb begin
        wr        = in_valid && in_ready_q;
        s1_adv    = s1_v_q && (!out_valid_q || out_ready);
        // avail lags the array write, so a read never hits a word being written
        rd_issue  = (avail_q != '0) && (!s1_v_q || s1_adv);
        avail_inc = IS_S10 ? wr_pend_q : wr;
        wr_pend_d = IS_S10 && wr;

        wptr_d    = wr       ? wptr_q + PTR_ONE : wptr_q;
        rptr_d    = rd_issue ? rptr_q + PTR_ONE : rptr_q;
        mem_cnt_d = mem_cnt_q + CW'(wr) - CW'(rd_issue);
        avail_d   = avail_q + CW'(avail_inc) - CW'(rd_issue);

        s1_v_d = s1_v_q;
        if (rd_issue)    s1_v_d = 1'b1;
        else if (s1_adv) s1_v_d = 1'b0;

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (s1_adv) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_dout;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        in_ready_d = mem_cnt_d < CW'(DEPTH);
        used_d     = UW'(mem_cnt_d) + UW'(s1_v_d) + UW'(out_valid_d);
    end

    // State registers; async clear discards everything at once
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            mem_cnt_q   <= '0;
            avail_q     <= '0;
            s1_v_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b0;
            wr_pend_q   <= 1'b0;
            used_q      <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            mem_cnt_q   <= mem_cnt_d;
            avail_q     <= avail_d;
            s1_v_q      <= s1_v_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            wr_pend_q   <= wr_pend_d;
            used_q      <= used_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign used      = used_q;
endmodule

// File: tb/tb_hps_adapter_util_scfifo.sv
// Directed bench for hps_adapter_util_scfifo: a default-family instance for
// function/boundary checks and an S10 instance for the extra write latency.
module tb_hps_adapter_util_scfifo;
    logic       clk = 1'b0;
    logic       aclr_n;
    logic [7:0] in_data, out_data;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [6:0] used;
    logic [7:0] s_in_data, s_out_data;
    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [6:0] s_used;

    int nvec = 0, nmiss = 0, n_acc = 0, n_pop = 0, cyc = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hps_adapter_util_scfifo #(.WIDTH(8), .ADDR_WIDTH(5), .FAMILY("Other")) u_dut (
        .clk(clk), .aclr_n(aclr_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .used(used));

    hps_adapter_util_scfifo #(.WIDTH(8), .ADDR_WIDTH(5), .FAMILY("S10")) u_s10 (
        .clk(clk), .aclr_n(aclr_n), .in_data(s_in_data), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .out_data(s_out_data), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .used(s_used));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmiss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with scoreboard bookkeeping; called just after a falling edge
    task automatic cycle();
        logic       stall;
        logic [7:0] held, exp;
        stall = out_valid && !out_ready;
        held  = out_data;
        if (in_valid && in_ready) begin
            sb.push_back(in_data);
            n_acc++;
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("sb_pop_empty", 32'(sb.size()), 32'd1);
            else begin
                exp = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(exp));
                n_pop++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (stall) chk("stall_hold", 32'(out_data), 32'(held));
    endtask

    initial begin
        int sent, t0, t1, g;
        logic fire;
        aclr_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_used", 32'(used), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        aclr_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Single word, latency N+2
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("single_ov_n", 32'(out_valid), 32'd0);
        chk("single_used_n", 32'(used), 32'd1);
        cycle();
        chk("single_ov_n1", 32'(out_valid), 32'd0);
        cycle();
        chk("single_ov_n2", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'hA5);
        chk("single_used_n2", 32'(used), 32'd1);
        cycle();
        chk("single_ov_done", 32'(out_valid), 32'd0);
        chk("single_used_done", 32'(used), 32'd0);

        // Empty boundary: out_ready with nothing queued changes nothing
        cycle();
        chk("empty_used", 32'(used), 32'd0);
        chk("empty_ov", 32'(out_valid), 32'd0);

        // Fill with no consumer
        out_ready = 1'b0; in_valid = 1'b1; n_acc = 0; n_pop = 0;
        for (int k = 0; k < 45; k++) begin
            in_data = 8'(k + 16);
            cycle();
        end
        chk("fill_accepted", 32'(n_acc), 32'd34);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_used", 32'(used), 32'd34);
        in_valid = 1'b0; out_ready = 1'b1;
        g = 0;
        while (sb.size() > 0 && g < 200) begin cycle(); g++; end
        chk("fill_drained", 32'(n_pop), 32'd34);
        chk("fill_used_end", 32'(used), 32'd0);

        // Streaming with wrap, one word per cycle
        n_pop = 0; sent = 0; t0 = 0; t1 = 0; g = 0;
        out_ready = 1'b1;
        while ((sent < 100 || sb.size() > 0) && g < 400) begin
            in_valid = (sent < 100);
            in_data  = 8'(sent);
            fire = in_valid && in_ready;
            if (out_valid && out_ready) begin
                if (n_pop == 0) t0 = cyc;
                t1 = cyc;
            end
            cycle();
            if (fire) sent++;
            g++;
        end
        in_valid = 1'b0;
        chk("stream_count", 32'(n_pop), 32'd100);
        chk("stream_span", 32'(t1 - t0), 32'd99);

        // Random output backpressure, 1000 words
        n_pop = 0; sent = 0; g = 0;
        while ((sent < 1000 || sb.size() > 0) && g < 20000) begin
            in_valid  = (sent < 1000);
            in_data   = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            fire = in_valid && in_ready;
            cycle();
            if (fire) sent++;
            g++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("bp_count", 32'(n_pop), 32'd1000);
        chk("bp_used_end", 32'(used), 32'd0);

        // Reset mid-stream at used=10
        in_valid = 1'b1; g = 0;
        while (used != 7'd10 && g < 50) begin
            in_data = 8'(g + 100);
            cycle();
            g++;
        end
        in_valid = 1'b0;
        chk("mid_used_pre", 32'(used), 32'd10);
        #2 aclr_n = 1'b0;
        #1;
        chk("mid_ov", 32'(out_valid), 32'd0);
        chk("mid_used", 32'(used), 32'd0);
        chk("mid_data", 32'(out_data), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        aclr_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_ready", 32'(in_ready), 32'd1);
        n_pop = 0;
        in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0; g = 0;
        while (sb.size() > 0 && g < 10) begin cycle(); g++; end
        chk("mid_next_word", 32'(n_pop), 32'd1);

        // S10 latency: N+3, no read issue at N+1
        repeat (2) @(negedge clk);
        chk("s10_ready", 32'(s_in_ready), 32'd1);
        s_in_valid = 1'b1; s_in_data = 8'h5A; s_out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        s_in_valid = 1'b0;
        chk("s10_ov_n", 32'(s_out_valid), 32'd0);
        chk("s10_no_issue_n1", 32'(u_s10.rd_issue), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("s10_ov_n1", 32'(s_out_valid), 32'd0);
        chk("s10_issue_n2", 32'(u_s10.rd_issue), 32'd1);
        @(posedge clk); @(negedge clk);
        chk("s10_ov_n2", 32'(s_out_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("s10_ov_n3", 32'(s_out_valid), 32'd1);
        chk("s10_data", 32'(s_out_data), 32'h5A);
        @(posedge clk); @(negedge clk);
        chk("s10_used_end", 32'(s_used), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end
endmodule
